// File: rtl/vector_magnitude_nd.sv
// Euclidean magnitude (or squared magnitude) of an N-channel signed fixed-point vector.
// Latency: N_CHANNELS+S+1 cycles from accept to out_valid (mode 0), N_CHANNELS+1 (mode 1).
// Backpressure: one vector in flight; in_ready only in IDLE, results held in DONE until out_ready.
module vector_magnitude_nd #(
    parameter int N_CHANNELS        = 3,
    parameter int INPUT_WIDTH       = 8,
    parameter int INPUT_FRAC_WIDTH  = 7,
    parameter int OUTPUT_WIDTH      = 8,
    parameter int OUTPUT_FRAC_WIDTH = 7
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_CHANNELS*INPUT_WIDTH-1:0]  in_data,
    input  logic                               in_valid,
    input  logic                               in_mode,
    output logic                               in_ready,
    output logic [OUTPUT_WIDTH-1:0]            out_r,
    output logic [N_CHANNELS*OUTPUT_WIDTH-1:0] out_sq,
    output logic                               out_overflow,
    output logic                               out_valid,
    input  logic                               out_ready
);

    // Square width, accumulator width (rounded up to even so the root has whole digits)
    localparam int SQW   = 2 * INPUT_WIDTH;
    localparam int LOGN  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 0;
    localparam int SUMW0 = SQW + LOGN;
    localparam int SUMW  = SUMW0 + (SUMW0 % 2);
    localparam int S     = SUMW / 2;
    localparam int RW    = S + 2;
    localparam int CNTW  = $clog2(N_CHANNELS + S + 2);
    // Wide enough that left-aligning any internal value never drops bits before the saturation test
    localparam int ALW   = SUMW + OUTPUT_FRAC_WIDTH + OUTPUT_WIDTH;

    localparam logic [CNTW-1:0] CNT_SQ_LAST = CNTW'(N_CHANNELS);
    localparam logic [CNTW-1:0] CNT_RT_LAST = CNTW'(S - 1);
    localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        SQRT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N_CHANNELS*INPUT_WIDTH-1:0] data_q;
    logic                              mode_q;
    logic [CNTW-1:0]                   cnt;
    logic [SQW-1:0]                    prod_q;
    logic [SUMW-1:0]                   acc;
    logic [SQW-1:0]                    sq_raw [N_CHANNELS];
    logic [SUMW-1:0]                   rad;
    logic [RW-1:0]                     rem;
    logic [S-1:0]                      root;

    logic signed [INPUT_WIDTH-1:0]     chan;
    logic signed [SQW-1:0]             prod_s;
    logic [SUMW-1:0]                   acc_nxt;
    logic [RW+1:0]                     rem_trial;
    logic [RW+1:0]                     trial;
    logic                              digit;
    logic [RW-1:0]                     rem_nxt;
    logic [S-1:0]                      root_nxt;
    logic                              last_sq;
    logic                              last_rt;
    logic                              load_out;
    logic [SQW-1:0]                    sq_eff [N_CHANNELS];
    logic [OUTPUT_WIDTH:0]             r_conv;
    logic [OUTPUT_WIDTH:0]             sq_conv [N_CHANNELS];
    logic [N_CHANNELS*OUTPUT_WIDTH-1:0] sq_word;
    logic                              ovf_nxt;

    // Align a fixed-point value to OUTPUT_FRAC_WIDTH and saturate; MSB of result flags saturation
    function automatic logic [OUTPUT_WIDTH:0] fx_align(input logic [ALW-1:0] v, input int frac);
        logic [ALW-1:0] a;
        if (frac >= OUTPUT_FRAC_WIDTH) begin
            a = v >> (frac - OUTPUT_FRAC_WIDTH);
        end else begin
            a = v << (OUTPUT_FRAC_WIDTH - frac);
        end
        if (|a[ALW-1:OUTPUT_WIDTH]) begin
            return {1'b1, {OUTPUT_WIDTH{1'b1}}};
        end
        return {1'b0, a[OUTPUT_WIDTH-1:0]};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_sq   = (state == SQUARE) && (cnt == CNT_SQ_LAST);
    assign last_rt   = (state == SQRT) && (cnt == CNT_RT_LAST);
    assign load_out  = (last_sq && mode_q) || last_rt;

    // Shared multiplier: pick the channel addressed by the counter and square it
    always_comb begin
        chan = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (cnt == CNTW'(i)) begin
                chan = data_q[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
        prod_s  = chan * chan;
        acc_nxt = acc + SUMW'(prod_q);
    end

    // One restoring square-root digit: bring down two radicand bits, try (4*root+1)
    always_comb begin
        rem_trial = {rem, rad[SUMW-1 -: 2]};
        trial     = {2'b00, root, 2'b01};
        digit     = (rem_trial >= trial);
        rem_nxt   = digit ? RW'(rem_trial - trial) : RW'(rem_trial);
        root_nxt  = S'({root, digit});
    end

    // Output conversion; the final square is still in the product register on the last SQUARE cycle
    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            sq_eff[i] = sq_raw[i];
        end
        if (last_sq) begin
            sq_eff[N_CHANNELS-1] = prod_q;
        end
        ovf_nxt = 1'b0;
        sq_word = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            sq_conv[i] = fx_align(ALW'(sq_eff[i]), 2 * INPUT_FRAC_WIDTH);
            sq_word[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = sq_conv[i][OUTPUT_WIDTH-1:0];
            ovf_nxt = ovf_nxt | sq_conv[i][OUTPUT_WIDTH];
        end
        if (mode_q) begin
            r_conv = fx_align(ALW'(acc_nxt), 2 * INPUT_FRAC_WIDTH);
        end else begin
            r_conv = fx_align(ALW'(root_nxt), INPUT_FRAC_WIDTH);
        end
        ovf_nxt = ovf_nxt | r_conv[OUTPUT_WIDTH];
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: squared-magnitude mode skips the root entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = SQUARE;
            SQUARE: if (last_sq) state_nxt = mode_q ? DONE : SQRT;
            SQRT:   if (last_rt) state_nxt = DONE;
            DONE:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, pipelined square/accumulate, then one root digit per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
            prod_q <= '0;
            acc    <= '0;
            rad    <= '0;
            rem    <= '0;
            root   <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                sq_raw[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        mode_q <= in_mode;
                        cnt    <= '0;
                        acc    <= '0;
                    end
                end
                SQUARE: begin
                    prod_q <= SQW'(prod_s);
                    if (cnt != '0) begin
                        acc <= acc_nxt;
                        for (int i = 0; i < N_CHANNELS; i++) begin
                            if (cnt == CNTW'(i + 1)) begin
                                sq_raw[i] <= prod_q;
                            end
                        end
                    end
                    if (last_sq) begin
                        cnt  <= '0;
                        rad  <= acc_nxt;
                        rem  <= '0;
                        root <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SQRT: begin
                    rad  <= rad << 2;
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    cnt  <= cnt + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers update only on the edge that enters DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_r        <= '0;
            out_sq       <= '0;
            out_overflow <= 1'b0;
        end else if (load_out) begin
            out_r        <= r_conv[OUTPUT_WIDTH-1:0];
            out_sq       <= sq_word;
            out_overflow <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_vector_magnitude_nd.sv
// Scoreboard bench for vector_magnitude_nd with a plain-arithmetic reference model.
// Latency is measured from the accepting edge to the edge that raises out_valid.
// Backpressure is exercised by a long directed stall and by random out_ready.
module tb_vector_magnitude_nd;

    localparam int N   = 2;
    localparam int IW  = 8;
    localparam int IFW = 4;
    localparam int OW  = 8;
    localparam int OFW = 4;
    localparam int DW  = N * IW;
    localparam int S   = (2 * IW + $clog2(N) + 1) / 2;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_mode;
    logic          in_ready;
    logic [OW-1:0] out_r;
    logic [N*OW-1:0] out_sq;
    logic          out_overflow;
    logic          out_valid;
    logic          out_ready;

    typedef struct packed {
        logic [OW-1:0]   r;
        logic [N*OW-1:0] sq;
        logic            ovf;
        logic [31:0]     lat;
        logic [31:0]     acc_cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   rand_bp = 1'b0;
    bit   ready_force = 1'b1;

    vector_magnitude_nd #(
        .N_CHANNELS(N), .INPUT_WIDTH(IW), .INPUT_FRAC_WIDTH(IFW),
        .OUTPUT_WIDTH(OW), .OUTPUT_FRAC_WIDTH(OFW)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_mode(in_mode), .in_ready(in_ready), .out_r(out_r), .out_sq(out_sq),
        .out_overflow(out_overflow), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Fixed-point realignment and saturation, in plain integer arithmetic
    function automatic logic [OW:0] m_align(input longint v, input int frac);
        longint a;
        if (frac >= OFW) a = v >> (frac - OFW);
        else             a = v << (OFW - frac);
        if (a > (longint'(1) << OW) - 1) return {1'b1, {OW{1'b1}}};
        return {1'b0, a[OW-1:0]};
    endfunction

    function automatic exp_t model(input logic [DW-1:0] d, input logic m);
        exp_t        e;
        longint      sum;
        longint      x;
        longint      r;
        logic [OW:0] t;
        e   = '0;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            x   = longint'($signed(d[i*IW +: IW]));
            sum = sum + x * x;
            t   = m_align(x * x, 2 * IFW);
            e.sq[i*OW +: OW] = t[OW-1:0];
            e.ovf = e.ovf | t[OW];
        end
        if (m) begin
            t     = m_align(sum, 2 * IFW);
            e.lat = N + 1;
        end else begin
            r = 0;
            while ((r + 1) * (r + 1) <= sum) r++;
            t     = m_align(r, IFW);
            e.lat = N + S + 1;
        end
        e.r   = t[OW-1:0];
        e.ovf = e.ovf | t[OW];
        return e;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic m, input bit now);
        exp_t e;
        int   k;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 300) break;
        end
        if (k > 300) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end else begin
            e = model(d, m);
            e.acc_cyc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_mode  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) break;
            k++;
            if (k > 500) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: out handshake absent, required within 500 cycles");
                break;
            end
        end
    endtask

    // Monitor: compare at the first valid cycle, check stability while stalled, pop on handshake
    initial begin
        exp_t e;
        bit   prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: out_valid=1 with out_r=0x%0h, required no output", out_r);
                end else begin
                    e = q[0];
                    if (!prev_v) begin
                        check("latency", 64'(cyc - int'(e.acc_cyc)), 64'(e.lat));
                        check("out_r", 64'(out_r), 64'(e.r));
                        check("out_sq", 64'(out_sq), 64'(e.sq));
                        check("out_overflow", 64'(out_overflow), 64'(e.ovf));
                    end else begin
                        check("hold_outputs", 64'({out_r, out_sq, out_overflow}), 64'({e.r, e.sq, e.ovf}));
                    end
                    if (!out_ready) check("in_ready_in_done", 64'(in_ready), 64'(0));
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_v = (reset === 1'b1) && out_valid && !out_ready;
        end
    end

    function automatic logic [IW-1:0] pick_comp();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'h00;
            default: return IW'($urandom);
        endcase
    endfunction

    initial begin
        int k;
        logic [DW-1:0] d;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_r", 64'(out_r), 64'(0));
        check("rst_out_sq", 64'(out_sq), 64'(0));
        check("rst_out_overflow", 64'(out_overflow), 64'(0));

        // Accept on the first edge after release: 3.0, 4.0 magnitude
        @(posedge clk);
        #1;
        reset = 1'b1;
        send({8'h40, 8'h30}, 1'b0, 1'b1);
        wait_done();
        send({8'h00, 8'hD0}, 1'b0, 1'b0);
        wait_done();
        send({8'h10, 8'h10}, 1'b1, 1'b0);
        wait_done();
        send({8'h80, 8'h80}, 1'b0, 1'b0);
        wait_done();

        // Long stall in DONE with a competing vector presented
        ready_force = 1'b0;
        send({8'h25, 8'hE3}, 1'b0, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 100);
        check("stall_out_valid", 64'(out_valid), 64'(1));
        repeat (20) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        ready_force = 1'b1;
        wait_done();

        // Reset in the middle of the root iterations
        send({8'h40, 8'h30}, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_r", 64'(out_r), 64'(0));
        check("midrst_out_overflow", 64'(out_overflow), 64'(0));
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        send({8'hC8, 8'h19}, 1'b0, 1'b0);
        wait_done();

        // Randomised vectors and modes under random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < N; c++) d[c*IW +: IW] = pick_comp();
            send(d, 1'($urandom_range(0, 1)), 1'b0);
            wait_done();
        end
        rand_bp = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
